// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> byte-wide instruction memory, holds the CPU in reset until done.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader #(
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  input  logic              reload_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CMP_W  = CNT_W + 1;
  localparam int unsigned BYTE_W = 8;
  localparam logic [CMP_W-1:0] LEN_MAX = CMP_W'(MEM_BYTES);

  typedef enum logic [2:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
`ifdef IMEM_LOADER_CSUM_EN
    ST_CSUM,
`endif
    ST_DONE,
    ST_ERROR
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    len_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [BYTE_W-1:0]   wr_data_q;
  logic                cpu_rst_q;
  logic                done_q;
  logic                err_q;

  logic [CNT_W-1:0]    len_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                len_big;
  logic                accept;
`ifdef IMEM_LOADER_CSUM_EN
  logic [BYTE_W-1:0]   csum_q;
  logic [BYTE_W-1:0]   csum_d;
`endif

  // Ready is purely a function of state and is forced low while reset is held.
  assign in_ready_o = rst_ni && (state_q != ST_DONE) && (state_q != ST_ERROR);
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    len_d   = {len_q[CNT_W-1:BYTE_W], in_data_i};
    cnt_d   = cnt_q + CNT_W'(1);
    len_big = CMP_W'(len_d) > LEN_MAX;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d  = csum_q ^ in_data_i;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_LEN_HI;
      len_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        ST_LEN_HI: begin
          if (accept) begin
            len_q[CNT_W-1:BYTE_W] <= in_data_i;
            state_q               <= ST_LEN_LO;
          end
        end

        ST_LEN_LO: begin
          if (accept) begin
            len_q[BYTE_W-1:0] <= in_data_i;
            cnt_q             <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            // Cleared here too so an empty image checks against zero.
            csum_q            <= '0;
`endif
            if (len_big) begin
              state_q <= ST_ERROR;
              err_q   <= 1'b1;
            end else if (len_d == '0) begin
`ifdef IMEM_LOADER_CSUM_EN
              state_q   <= ST_CSUM;
`else
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
`endif
            end else begin
              state_q <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (accept) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= ADDR_W'(cnt_q);
            wr_data_q <= in_data_i;
            cnt_q     <= cnt_d;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q    <= csum_d;
`endif
            if (cnt_d == len_q) begin
`ifdef IMEM_LOADER_CSUM_EN
              state_q   <= ST_CSUM;
`else
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
`endif
            end
          end
        end

`ifdef IMEM_LOADER_CSUM_EN
        ST_CSUM: begin
          if (accept) begin
            if (in_data_i == csum_q) begin
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else begin
              state_q <= ST_ERROR;
              err_q   <= 1'b1;
            end
          end
        end
`endif

        ST_DONE, ST_ERROR: begin
          // Memory is left intact; the next image overwrites from address 0.
          if (reload_i) begin
            state_q   <= ST_LEN_HI;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_LEN_HI;
        end
      endcase
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign cpu_rst_o = cpu_rst_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; follows IMEM_LOADER_CSUM_EN like the design.
module tb_imem_loader;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       reload;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       cpu_rst;
  logic       done;
  logic       err;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [15:0] wr_log[$];
  logic [7:0]  stim[$];

  imem_loader #(.MEM_BYTES(256), .ADDR_W(8)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .reload_i   (reload),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .cpu_rst_o  (cpu_rst),
    .done_o     (done),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every write strobe is recorded as {addr, data}.
  always @(negedge clk) begin
    if (wr_en === 1'b1) wr_log.push_back({wr_addr, wr_data});
  end

  task automatic build_image(input logic [7:0] data[$]);
    logic [7:0]  x;
    logic [15:0] len;
    len = 16'(data.size());
    x   = 8'h00;
    stim = {};
    stim.push_back(len[15:8]);
    stim.push_back(len[7:0]);
    foreach (data[i]) begin
      stim.push_back(data[i]);
      x = x ^ data[i];
    end
`ifdef IMEM_LOADER_CSUM_EN
    stim.push_back(x);
`endif
  endtask

  // Presents stim bytes one per cycle, optionally with idle cycles between them.
  task automatic drive_stim(input int gap);
    foreach (stim[i]) begin
      in_valid = 1'b1;
      in_data  = stim[i];
      @(negedge clk);
      if (gap > 0 && i != stim.size() - 1) begin
        in_valid = 1'b0;
        in_data  = 8'hEE;
        repeat (gap) @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", in_ready); else pass_cnt++;
    chk_cnt++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", wr_en); else pass_cnt++;
    chk_cnt++; if (wr_addr !== 8'h00) $display("FAIL reset_wr_addr: got %h want 00", wr_addr); else pass_cnt++;
    chk_cnt++; if (wr_data !== 8'h00) $display("FAIL reset_wr_data: got %h want 00", wr_data); else pass_cnt++;
    chk_cnt++; if (cpu_rst !== 1'b1) $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    chk_cnt++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready_after: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_basic();
    int base;
    logic [15:0] exp_w[4];
    exp_w = '{16'h0020, 16'h0108, 16'h0200, 16'h0305};
    base = wr_log.size();
    build_image('{8'h20, 8'h08, 8'h00, 8'h05});
    drive_stim(0);
    chk_cnt++; if (done !== 1'b1) $display("FAIL basic_done: got %b want 1", done); else pass_cnt++;
    chk_cnt++; if (cpu_rst !== 1'b0) $display("FAIL basic_cpu_rst: got %b want 0", cpu_rst); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL basic_ready: got %b want 0", in_ready); else pass_cnt++;
`ifndef IMEM_LOADER_CSUM_EN
    chk_cnt++; if (wr_en !== 1'b1) $display("FAIL basic_last_wr_with_done: got %b want 1", wr_en); else pass_cnt++;
`endif
    @(negedge clk);
    chk_cnt++; if (wr_log.size() - base !== 4) $display("FAIL basic_wr_count: got %0d want 4", wr_log.size() - base); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      if (base + i < wr_log.size()) begin
        chk_cnt++;
        if (wr_log[base+i] !== exp_w[i]) $display("FAIL basic_wr%0d: got %h want %h", i, wr_log[base+i], exp_w[i]);
        else pass_cnt++;
      end
    end
    // A byte offered after the image must not be consumed.
    in_valid = 1'b1; in_data = 8'hFF;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk_cnt++; if (wr_log.size() - base !== 4) $display("FAIL basic_extra_byte: got %0d writes want 4", wr_log.size() - base); else pass_cnt++;
    chk_cnt++; if (done !== 1'b1) $display("FAIL basic_done_hold: got %b want 1", done); else pass_cnt++;
    pulse_reload();
    chk_cnt++; if (done !== 1'b0) $display("FAIL reload_done: got %b want 0", done); else pass_cnt++;
    chk_cnt++; if (cpu_rst !== 1'b1) $display("FAIL reload_cpu_rst: got %b want 1", cpu_rst); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reload_ready: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_two_bytes();
    int base;
    base = wr_log.size();
    build_image('{8'hAA, 8'hBB});
    drive_stim(0);
    chk_cnt++; if (done !== 1'b1) $display("FAIL two_done: got %b want 1", done); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL two_ready_after: got %b want 0", in_ready); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (wr_log.size() - base !== 2) $display("FAIL two_wr_count: got %0d want 2", wr_log.size() - base); else pass_cnt++;
    if (wr_log.size() - base >= 2) begin
      chk_cnt++; if (wr_log[base] !== 16'h00AA) $display("FAIL two_wr0: got %h want 00aa", wr_log[base]); else pass_cnt++;
      chk_cnt++; if (wr_log[base+1] !== 16'h01BB) $display("FAIL two_wr1: got %h want 01bb", wr_log[base+1]); else pass_cnt++;
    end
    pulse_reload();
  endtask

`ifdef IMEM_LOADER_CSUM_EN
  task automatic test_csum_bad();
    int base;
    base = wr_log.size();
    stim = '{8'h00, 8'h04, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
    drive_stim(0);
    chk_cnt++; if (err !== 1'b1) $display("FAIL csum_bad_err: got %b want 1", err); else pass_cnt++;
    chk_cnt++; if (cpu_rst !== 1'b1) $display("FAIL csum_bad_cpu_rst: got %b want 1", cpu_rst); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL csum_bad_done: got %b want 0", done); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL csum_bad_ready: got %b want 0", in_ready); else pass_cnt++;
    chk_cnt++; if (wr_log.size() - base !== 4) $display("FAIL csum_bad_wr_count: got %0d want 4", wr_log.size() - base); else pass_cnt++;
    pulse_reload();
  endtask
`endif

  task automatic test_oversize();
    int base;
    base = wr_log.size();
    stim = '{8'h01, 8'h01};
    drive_stim(0);
    chk_cnt++; if (err !== 1'b1) $display("FAIL over_err: got %b want 1", err); else pass_cnt++;
    chk_cnt++; if (cpu_rst !== 1'b1) $display("FAIL over_cpu_rst: got %b want 1", cpu_rst); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL over_ready: got %b want 0", in_ready); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (wr_log.size() - base !== 0) $display("FAIL over_wr_count: got %0d want 0", wr_log.size() - base); else pass_cnt++;
    pulse_reload();
    chk_cnt++; if (err !== 1'b0) $display("FAIL over_reload_err: got %b want 0", err); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL over_reload_ready: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_len_max();
    int base;
    int bad;
    logic [7:0] d[$];
    for (int i = 0; i < 256; i++) d.push_back(8'(i) ^ 8'h5A);
    base = wr_log.size();
    build_image(d);
    drive_stim(0);
    chk_cnt++; if (done !== 1'b1 || err !== 1'b0) $display("FAIL max_done: got done=%b err=%b want 1/0", done, err); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (wr_log.size() - base !== 256) $display("FAIL max_wr_count: got %0d want 256", wr_log.size() - base); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (base + i >= wr_log.size() || wr_log[base+i] !== {8'(i), 8'(i) ^ 8'h5A}) bad++;
    chk_cnt++; if (bad !== 0) $display("FAIL max_wr_content: got %0d bad writes want 0", bad); else pass_cnt++;
    pulse_reload();
  endtask

  task automatic test_len_zero();
    int base;
    base = wr_log.size();
    build_image('{});
    drive_stim(0);
    chk_cnt++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else pass_cnt++;
    chk_cnt++; if (cpu_rst !== 1'b0) $display("FAIL zero_cpu_rst: got %b want 0", cpu_rst); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (wr_log.size() - base !== 0) $display("FAIL zero_wr_count: got %0d want 0", wr_log.size() - base); else pass_cnt++;
    pulse_reload();
  endtask

  task automatic test_throttled();
    int base;
    int bad;
    logic [7:0] d[$];
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    base = wr_log.size();
    build_image(d);
    fork
      drive_stim(1);
      begin
        // Reload mid-image must be ignored.
        repeat (6) @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
      end
    join
    chk_cnt++; if (done !== 1'b1) $display("FAIL thr_done: got %b want 1", done); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (wr_log.size() - base !== 8) $display("FAIL thr_wr_count: got %0d want 8", wr_log.size() - base); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (base + i >= wr_log.size() || wr_log[base+i] !== {8'(i), d[i]}) bad++;
    chk_cnt++; if (bad !== 0) $display("FAIL thr_wr_order: got %0d bad writes want 0", bad); else pass_cnt++;
    pulse_reload();
  endtask

  task automatic test_reset_mid();
    int base;
    stim = '{8'h00, 8'h04, 8'h20, 8'h08};
    drive_stim(0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_cnt++; if (wr_en !== 1'b0) $display("FAIL mid_wr_en: got %b want 0", wr_en); else pass_cnt++;
    chk_cnt++; if (wr_addr !== 8'h00 || wr_data !== 8'h00) $display("FAIL mid_wr_bus: got %h/%h want 00/00", wr_addr, wr_data); else pass_cnt++;
    chk_cnt++; if (cpu_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0) $display("FAIL mid_status: got %b%b%b want 100", cpu_rst, done, err); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL mid_ready: got %b want 0", in_ready); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    base = wr_log.size();
    build_image('{8'h20, 8'h08, 8'h00, 8'h05});
    drive_stim(0);
    chk_cnt++; if (done !== 1'b1 || cpu_rst !== 1'b0) $display("FAIL mid_reload_done: got done=%b cpu_rst=%b want 1/0", done, cpu_rst); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (wr_log.size() - base !== 4) $display("FAIL mid_wr_count: got %0d want 4", wr_log.size() - base); else pass_cnt++;
    if (wr_log.size() - base >= 4) begin
      chk_cnt++; if (wr_log[base] !== 16'h0020) $display("FAIL mid_wr0: got %h want 0020", wr_log[base]); else pass_cnt++;
      chk_cnt++; if (wr_log[base+3] !== 16'h0305) $display("FAIL mid_wr3: got %h want 0305", wr_log[base+3]); else pass_cnt++;
    end
    pulse_reload();
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_two_bytes();
`ifdef IMEM_LOADER_CSUM_EN
    test_csum_bad();
`endif
    test_oversize();
    test_len_max();
    test_len_zero();
    test_throttled();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the single-cycle MIPS datapath's instruction memory. It accepts a length-prefixed byte stream over a valid/ready handshake and writes the bytes sequentially into the byte-wide instruction memory starting at address 0. It holds the datapath in reset until a complete, checked image has been written, then releases it.

## Interface
- `MEM_BYTES`, 256: instruction memory size in bytes; images longer than this are rejected.
- `ADDR_W`, 8: instruction memory byte-address width; must satisfy 2^ADDR_W ≥ MEM_BYTES.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  upstream byte valid.
- `in_data`  in  8  upstream byte.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `reload`  in  1  single-cycle pulse; restarts loading from DONE or ERROR.
- `wr_en`  out  1  instruction memory byte write strobe.
- `wr_addr`  out  ADDR_W  byte address.
- `wr_data`  out  8  byte to write.
- `cpu_rst`  out  1  active-high reset to the datapath's PC.
- `done`  out  1  image loaded and accepted.
- `err`  out  1  image rejected.

## Operation
- Stream format: LEN_HI, LEN_LO, then LEN data bytes, then a checksum byte (see Configuration). LEN is a 16-bit byte count, big-endian.
- Data byte k is written to address k. Byte order is big-endian, consistent with the fetch order `{mem[a],mem[a+1],mem[a+2],mem[a+3]}`.
- A byte is accepted on a rising edge where `in_valid & in_ready`. `in_ready` is a combinational function of state:
  - 1 in LEN_HI, LEN_LO, DATA and CSUM.
  - 0 in DONE and ERROR, and while `rst` is low.
- States and transitions:
  - LEN_HI: accept → capture LEN[15:8] → LEN_LO.
  - LEN_LO: accept → capture LEN[7:0].
    - If LEN > MEM_BYTES → ERROR.
    - If LEN == 0 → CSUM, or DONE when the checksum is compiled out.
    - Otherwise → DATA, with the byte counter cleared and the running checksum set to 0.
  - DATA: each accept writes the byte, increments the counter and XORs the byte into the running checksum. On accepting byte LEN-1 → CSUM, or DONE when the checksum is compiled out.
  - CSUM: accept.
    - If the byte equals the running XOR → DONE.
    - Otherwise → ERROR.
  - DONE: `cpu_rst`=0, `done`=1. `reload` → LEN_HI.
  - ERROR: `cpu_rst`=1, `err`=1. `reload` → LEN_HI.
- `reload` in LEN_HI, LEN_LO, DATA or CSUM is ignored.
- On re-entry to LEN_HI via `reload`:
  - `done`, `err` and the counter clear.
  - `cpu_rst` re-asserts.
  - Memory contents are not cleared; the new image overwrites from address 0.
- Counter width is 16 bits. `wr_addr` is the counter's low ADDR_W bits; the LEN check guarantees no wrap.

## Timing
- Reset values (`rst` low at an edge): state = LEN_HI, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cpu_rst`=1, `done`=0, `err`=0, counter=0, checksum=0, LEN=0.
- Reset mid-image aborts the load immediately. Partially written bytes remain in memory.
- `wr_en`, `wr_addr` and `wr_data` are registered. They are valid in the cycle after the accepting edge, and `wr_en` is high for exactly one cycle per data byte.
- Back-to-back accepts give one write per cycle; throughput is 1 byte/clk.
- `cpu_rst`, `done` and `err` are registered. They change on the same edge the state enters DONE or ERROR. The final `wr_en` pulse coincides with the first DONE cycle, and the IM write completes at that edge, before the PC leaves 0.
- The loader drops `in_ready` in the same cycle it enters DONE or ERROR, so no byte beyond the image is consumed.

## Configuration
- `IMEM_LOADER_CSUM_EN` defined:
  - CSUM state present; a checksum byte is required.
  - A mismatch → ERROR.
- `IMEM_LOADER_CSUM_EN` undefined:
  - No CSUM state and no checksum logic.
  - The last data byte (or LEN==0) goes directly to DONE.
  - ERROR is reachable only via oversize LEN.

## Test plan
- Reset then stream 00 04 | 20 08 00 05 | 2D (XOR = 0x2D), `in_valid` held high:
  - four `wr_en` pulses at addresses 0..3 with data 20,08,00,05;
  - `done`=1 and `cpu_rst`=0 on the edge accepting 2D.
- Same image with checksum 0x2C:
  - four writes occur;
  - `err`=1, `cpu_rst` stays 1, `in_ready`=0.
- LEN = 0x0101 (257) with MEM_BYTES=256:
  - ERROR right after LEN_LO, no `wr_en` pulses;
  - then `reload` → `in_ready`=1, `err`=0.
- `in_valid` toggled every other cycle on an 8-byte image:
  - exactly 8 writes at addresses 0..7, in order, none duplicated.
- Assert `rst` low after 2 of 4 data bytes, then resend the full image:
  - after reset, outputs match the reset values;
  - the reload completes with `done`=1.
- With `IMEM_LOADER_CSUM_EN` undefined, stream 00 02 | AA BB:
  - `done`=1 after BB;
  - a following byte sees `in_ready`=0.
